// File: rtl/vector_writeback_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vector_writeback_unit_pkg                                     |
// | Description : Shared types and helpers for the vector writeback sequencer.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package vector_writeback_unit_pkg;

    // Selected element width; encoding 3 is reserved and means "write nothing"
    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } vsew_e;

    // Writeback sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } vwb_state_e;

    // Index of the final beat of a register group of 2**lmul registers
    function automatic logic [2:0] lmul_last_beat(input logic [1:0] lmul);
        logic [2:0] last;
        case (lmul)
            2'd0:    last = 3'd0;
            2'd1:    last = 3'd1;
            2'd2:    last = 3'd3;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_writeback_unit_byte_en.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vector_byte_enable_gen                                        |
// | Description : Per-byte write enables for one register of a vector group,    |
// |               applying the vl tail and the optional v0 mask.               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module vector_byte_enable_gen
    import vector_writeback_unit_pkg::*;
#(
    parameter int VLEN  = 64,
    parameter int VLENB = VLEN / 8
) (
    input  logic [2:0]             beat,
    input  logic [1:0]             sew,
    input  logic [$clog2(VLEN):0]  vl,
    input  logic                   vm,
    input  logic [VLEN-1:0]        v0_mask,
    output logic [VLENB-1:0]       enable
);

    localparam int c_ELEM_W = $clog2(VLEN) + 1;

    // Each byte belongs to exactly one element per SEW; it is written only when
    // that element lies below vl and is either unmasked or selected by v0.
    for (genvar b = 0; b < VLENB; b++) begin : g_byte
        logic [c_ELEM_W-1:0] w_e8;
        logic [c_ELEM_W-1:0] w_e16;
        logic [c_ELEM_W-1:0] w_e32;
        logic                w_act8;
        logic                w_act16;
        logic                w_act32;

        assign w_e8  = c_ELEM_W'(beat) * c_ELEM_W'(VLENB)     + c_ELEM_W'(b);
        assign w_e16 = c_ELEM_W'(beat) * c_ELEM_W'(VLENB / 2) + c_ELEM_W'(b / 2);
        assign w_e32 = c_ELEM_W'(beat) * c_ELEM_W'(VLENB / 4) + c_ELEM_W'(b / 4);

        // Element indices never reach VLEN, so the low bits address v0 directly
        assign w_act8  = (w_e8  < vl) && (vm || v0_mask[w_e8[c_ELEM_W-2:0]]);
        assign w_act16 = (w_e16 < vl) && (vm || v0_mask[w_e16[c_ELEM_W-2:0]]);
        assign w_act32 = (w_e32 < vl) && (vm || v0_mask[w_e32[c_ELEM_W-2:0]]);

        assign enable[b] = (sew == SEW8)  ? w_act8  :
                           (sew == SEW16) ? w_act16 :
                           (sew == SEW32) ? w_act32 : 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/vector_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vector_writeback_unit                                         |
// | Description : Turns a writeback command plus VLEN-wide result beats into    |
// |               byte-enabled register writes for the vector register bank.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module vector_writeback_unit
    import vector_writeback_unit_pkg::*;
#(
    parameter int VLEN  = 64,
    parameter int VLENB = VLEN / 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [4:0]             cmd_vd,
    input  logic [1:0]             cmd_lmul,
    input  logic [1:0]             cmd_sew,
    input  logic [$clog2(VLEN):0]  cmd_vl,
    input  logic                   cmd_vm,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [VLEN-1:0]        data_result,
    input  logic [VLEN-1:0]        v0_mask,
    output logic [VLENB-1:0]       enable,
    output logic [4:0]             vd_addr,
    output logic [VLEN-1:0]        result,
    output logic                   busy,
    output logic                   done
);

    localparam int c_VL_W = $clog2(VLEN) + 1;

    vwb_state_e          r_state;
    vwb_state_e          w_state_next;
    logic [4:0]          r_vd;
    logic [1:0]          r_lmul;
    logic [1:0]          r_sew;
    logic [c_VL_W-1:0]   r_vl;
    logic                r_vm;
    logic [2:0]          r_beat;
    logic                w_cmd_accept;
    logic                w_beat_accept;
    logic                w_last_beat;
    logic                w_vl_zero;
    logic [VLENB-1:0]    w_enable;

    assign cmd_ready     = (r_state == IDLE);
    assign data_ready    = (r_state == WRITE);
    assign busy          = (r_state != IDLE);
    assign w_cmd_accept  = cmd_valid && cmd_ready;
    assign w_beat_accept = data_valid && data_ready;
    assign w_last_beat   = (r_beat == lmul_last_beat(r_lmul));
    assign w_vl_zero     = (cmd_vl == '0);

    vector_byte_enable_gen #(
        .VLEN  (VLEN),
        .VLENB (VLENB)
    ) u_byte_en (
        .beat    (r_beat),
        .sew     (r_sew),
        .vl      (r_vl),
        .vm      (r_vm),
        .v0_mask (v0_mask),
        .enable  (w_enable)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: an empty command skips straight to DONE; a group ends on its last beat
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cmd_accept) w_state_next = w_vl_zero ? DONE : WRITE;
            WRITE:   if (w_beat_accept && w_last_beat) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the command on accept and count beats through the register group
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vd   <= '0;
            r_lmul <= '0;
            r_sew  <= '0;
            r_vl   <= '0;
            r_vm   <= 1'b0;
            r_beat <= '0;
        end else if (w_cmd_accept) begin
            r_vd   <= cmd_vd;
            r_lmul <= cmd_lmul;
            r_sew  <= cmd_sew;
            r_vl   <= cmd_vl;
            r_vm   <= cmd_vm;
            r_beat <= '0;
        end else if (w_beat_accept) begin
            r_beat <= r_beat + 3'd1;
        end
    end

    // Register-bank write port: a write only in the cycle after an accepted beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable  <= '0;
            vd_addr <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            enable <= w_beat_accept ? w_enable : '0;
            done   <= (w_beat_accept && w_last_beat) || (w_cmd_accept && w_vl_zero);
            if (w_beat_accept) begin
                vd_addr <= r_vd + {2'b00, r_beat};
                result  <= data_result;
            end
        end
    end

    // A masked operation must not target v0 itself
    a_masked_vd0 : assert property (@(posedge clk) disable iff (!reset_n)
        w_cmd_accept |-> (cmd_vm || (cmd_vd != 5'd0)));

endmodule
`default_nettype wire

// File: tb/tb_vector_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vector_writeback_unit                                      |
// | Description : Directed self-checking bench for vector_writeback_unit.       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vector_writeback_unit;

    localparam int VLEN  = 64;
    localparam int VLENB = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_vd;
    logic [1:0]        cmd_lmul;
    logic [1:0]        cmd_sew;
    logic [6:0]        cmd_vl;
    logic              cmd_vm;
    logic              data_valid;
    logic              data_ready;
    logic [VLEN-1:0]   data_result;
    logic [VLEN-1:0]   v0_mask;
    logic [VLENB-1:0]  enable;
    logic [4:0]        vd_addr;
    logic [VLEN-1:0]   result;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    vector_writeback_unit #(
        .VLEN  (VLEN),
        .VLENB (VLENB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_vd      (cmd_vd),
        .cmd_lmul    (cmd_lmul),
        .cmd_sew     (cmd_sew),
        .cmd_vl      (cmd_vl),
        .cmd_vm      (cmd_vm),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_result (data_result),
        .v0_mask     (v0_mask),
        .enable      (enable),
        .vd_addr     (vd_addr),
        .result      (result),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one accepting edge
    task automatic send_cmd(input logic [4:0] vd, input logic [1:0] lmul, input logic [1:0] sew,
                            input logic [6:0] vl, input logic vm);
        cmd_vd    = vd;
        cmd_lmul  = lmul;
        cmd_sew   = sew;
        cmd_vl    = vl;
        cmd_vm    = vm;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_vd      = '0;
        cmd_lmul    = '0;
        cmd_sew     = '0;
        cmd_vl      = '0;
        cmd_vm      = 1'b1;
        data_valid  = 1'b0;
        data_result = '0;
        v0_mask     = '0;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_vd_addr", 64'(vd_addr), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        reset_n = 1'b1;
        tick();

        // SEW8, single register, vl=5 -> bytes 0..4
        send_cmd(5'd3, 2'd0, 2'd0, 7'd5, 1'b1);
        chk("t1_data_ready", 64'(data_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
        data_valid  = 1'b1;
        data_result = 64'h1122_3344_5566_7788;
        tick();
        data_valid = 1'b0;
        chk("t1_enable", 64'(enable), 64'h1F);
        chk("t1_vd_addr", 64'(vd_addr), 64'd3);
        chk("t1_result", result, 64'h1122_3344_5566_7788);
        chk("t1_done", 64'(done), 64'd1);
        tick();
        chk("t1_enable_after", 64'(enable), 64'd0);
        chk("t1_done_after", 64'(done), 64'd0);
        chk("t1_cmd_ready_after", 64'(cmd_ready), 64'd1);

        // SEW32, two registers, vl=3 -> FF then 0F, back-to-back beats
        send_cmd(5'd4, 2'd1, 2'd2, 7'd3, 1'b1);
        data_valid  = 1'b1;
        data_result = 64'hAAAA_0000_BBBB_1111;
        tick();
        chk("t2_b0_enable", 64'(enable), 64'hFF);
        chk("t2_b0_vd_addr", 64'(vd_addr), 64'd4);
        chk("t2_b0_done", 64'(done), 64'd0);
        data_result = 64'hCCCC_2222_DDDD_3333;
        tick();
        data_valid = 1'b0;
        chk("t2_b1_enable", 64'(enable), 64'h0F);
        chk("t2_b1_vd_addr", 64'(vd_addr), 64'd5);
        chk("t2_b1_result", result, 64'hCCCC_2222_DDDD_3333);
        chk("t2_b1_done", 64'(done), 64'd1);
        tick();

        // SEW16 masked, vl=4, v0=0101 -> elements 0 and 2 -> 8'h33
        v0_mask = 64'h5;
        send_cmd(5'd2, 2'd0, 2'd1, 7'd4, 1'b0);
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("t3_enable", 64'(enable), 64'h33);
        chk("t3_vd_addr", 64'(vd_addr), 64'd2);
        chk("t3_done", 64'(done), 64'd1);
        tick();

        // SEW32 masked over two registers, v0=1010 -> elements 1 and 3 -> F0, F0
        v0_mask = 64'hA;
        send_cmd(5'd10, 2'd1, 2'd2, 7'd4, 1'b0);
        data_valid = 1'b1;
        tick();
        chk("t3b_b0_enable", 64'(enable), 64'hF0);
        tick();
        data_valid = 1'b0;
        chk("t3b_b1_enable", 64'(enable), 64'hF0);
        chk("t3b_b1_vd_addr", 64'(vd_addr), 64'd11);
        tick();
        v0_mask = '0;

        // vl=0: no beats taken even with data_valid high, done after the accept
        data_valid = 1'b1;
        send_cmd(5'd6, 2'd0, 2'd0, 7'd0, 1'b1);
        chk("t4_data_ready", 64'(data_ready), 64'd0);
        chk("t4_enable", 64'(enable), 64'd0);
        chk("t4_done", 64'(done), 64'd1);
        tick();
        chk("t4_done_after", 64'(done), 64'd0);
        chk("t4_enable_after", 64'(enable), 64'd0);
        chk("t4_cmd_ready", 64'(cmd_ready), 64'd1);
        data_valid = 1'b0;

        // SEW encoding 3: beat consumed, nothing written
        send_cmd(5'd9, 2'd0, 2'd3, 7'd8, 1'b1);
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("t5_enable", 64'(enable), 64'd0);
        chk("t5_done", 64'(done), 64'd1);
        tick();

        // LMUL=8 with a gap before every beat; vl=60 leaves a tail in the last register
        send_cmd(5'd24, 2'd3, 2'd0, 7'd60, 1'b1);
        for (int i = 0; i < 8; i++) begin
            data_valid = 1'b0;
            tick();
            chk("t6_gap_enable", 64'(enable), 64'd0);
            if (i > 0) chk("t6_gap_vd_hold", 64'(vd_addr), 64'(24 + i - 1));
            data_valid  = 1'b1;
            data_result = 64'(i) * 64'h0101_0101_0101_0101;
            tick();
            chk("t6_vd_addr", 64'(vd_addr), 64'(24 + i));
            chk("t6_enable", 64'(enable), (i == 7) ? 64'h0F : 64'hFF);
            chk("t6_result", result, 64'(i) * 64'h0101_0101_0101_0101);
            chk("t6_done", 64'(done), (i == 7) ? 64'd1 : 64'd0);
        end
        data_valid = 1'b0;
        tick();
        chk("t6_idle", 64'(cmd_ready), 64'd1);

        // Reset after 2 of 4 beats abandons the command
        send_cmd(5'd8, 2'd2, 2'd0, 7'd32, 1'b1);
        data_valid = 1'b1;
        tick();
        chk("t7_b0_enable", 64'(enable), 64'hFF);
        tick();
        chk("t7_b1_enable", 64'(enable), 64'hFF);
        chk("t7_b1_vd_addr", 64'(vd_addr), 64'd9);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_enable", 64'(enable), 64'd0);
        chk("t7_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t7_rst_busy", 64'(busy), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t7_post_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t7_post_data_ready", 64'(data_ready), 64'd0);
        chk("t7_post_enable", 64'(enable), 64'd0);
        chk("t7_post_done", 64'(done), 64'd0);
        data_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
